// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer control for an async FIFO: Gray pointer, read-pointer sync, flags.
// Optional sticky overflow flag enabled by FIFO_WR_OVERFLOW_DETECT_EN.
module fifo_wr_ptr_ctrl #(
  parameter int ADDR_WIDTH       = 3,
  parameter int DEPTH            = 8,
  parameter int ALMOST_WR_MARGIN = 1,
  parameter int N_FLOP_CROSS     = 2
) (
  input  logic                  i_wr_clk,
  input  logic                  i_wr_rst_n,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [ADDR_WIDTH:0]   i_rdom_rd_ptr_gray,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [ADDR_WIDTH:0]   o_wr_ptr_bin,
  output logic [ADDR_WIDTH:0]   o_wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   o_wdom_rd_ptr_bin,
  output logic [ADDR_WIDTH:0]   o_wr_count,
  output logic                  o_wr_full,
  output logic                  o_wr_almost_full,
  output logic                  o_wr_overflow
);

  localparam int AW = ADDR_WIDTH;
  typedef logic [AW:0] ptr_t;
  localparam ptr_t AF_THR = ptr_t'(DEPTH - ALMOST_WR_MARGIN);

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  ptr_t r_wr_ptr_bin;
  ptr_t r_wr_ptr_gray;
  ptr_t r_sync [N_FLOP_CROSS];
  logic r_full;
  logic r_afull;

  logic w_accept;
  ptr_t w_ptr_next;
  ptr_t w_rd_bin;
  ptr_t w_cnt_next;
  logic w_full_next;

  assign w_accept    = i_wr_valid & ~r_full;
  assign w_ptr_next  = r_wr_ptr_bin + ptr_t'(w_accept);
  assign w_rd_bin    = gray2bin(r_sync[N_FLOP_CROSS-1]);
  assign w_cnt_next  = w_ptr_next - w_rd_bin;
  assign w_full_next = (w_ptr_next[AW] != w_rd_bin[AW]) &&
                       (w_ptr_next[AW-1:0] == w_rd_bin[AW-1:0]);

  always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
    if (!i_wr_rst_n) begin
      r_wr_ptr_bin  <= '0;
      r_wr_ptr_gray <= '0;
      r_full        <= 1'b0;
      r_afull       <= 1'b0;
    end else begin
      r_wr_ptr_bin  <= w_ptr_next;
      r_wr_ptr_gray <= w_ptr_next ^ (w_ptr_next >> 1);
      r_full        <= w_full_next;
      r_afull       <= (w_cnt_next >= AF_THR);
    end
  end

  // Only the last stage is consumed; earlier stages resolve metastability.
  always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
    if (!i_wr_rst_n) begin
      for (int i = 0; i < N_FLOP_CROSS; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_rdom_rd_ptr_gray;
      for (int i = 1; i < N_FLOP_CROSS; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

`ifdef FIFO_WR_OVERFLOW_DETECT_EN
  logic r_ovf;
  always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
    if (!i_wr_rst_n) begin
      r_ovf <= 1'b0;
    end else if (i_wr_valid && r_full) begin
      r_ovf <= 1'b1;
    end
  end
  assign o_wr_overflow = r_ovf;
`else
  assign o_wr_overflow = 1'b0;
`endif

  assign o_wr_ready        = ~r_full;
  assign o_wr_en           = w_accept;
  assign o_wr_addr         = r_wr_ptr_bin[AW-1:0];
  assign o_wr_ptr_bin      = r_wr_ptr_bin;
  assign o_wr_ptr_gray     = r_wr_ptr_gray;
  assign o_wdom_rd_ptr_bin = w_rd_bin;
  assign o_wr_count        = r_wr_ptr_bin - w_rd_bin;
  assign o_wr_full         = r_full;
  assign o_wr_almost_full  = r_afull;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Self-checking bench for fifo_wr_ptr_ctrl (AW=3, DEPTH=8, margin 1, 2 sync flops).
// Write addresses are scoreboarded; flags/pointers checked against a cycle model.
module tb_fifo_wr_ptr_ctrl;

  logic       i_wr_clk = 1'b0;
  logic       i_wr_rst_n = 1'b0;
  logic       i_wr_valid = 1'b0;
  logic [3:0] i_rdom_rd_ptr_gray = '0;
  logic       o_wr_ready;
  logic       o_wr_en;
  logic [2:0] o_wr_addr;
  logic [3:0] o_wr_ptr_bin;
  logic [3:0] o_wr_ptr_gray;
  logic [3:0] o_wdom_rd_ptr_bin;
  logic [3:0] o_wr_count;
  logic       o_wr_full;
  logic       o_wr_almost_full;
  logic       o_wr_overflow;

  fifo_wr_ptr_ctrl #(
    .ADDR_WIDTH(3), .DEPTH(8), .ALMOST_WR_MARGIN(1), .N_FLOP_CROSS(2)
  ) dut (
    .i_wr_clk(i_wr_clk),
    .i_wr_rst_n(i_wr_rst_n),
    .i_wr_valid(i_wr_valid),
    .o_wr_ready(o_wr_ready),
    .i_rdom_rd_ptr_gray(i_rdom_rd_ptr_gray),
    .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr),
    .o_wr_ptr_bin(o_wr_ptr_bin),
    .o_wr_ptr_gray(o_wr_ptr_gray),
    .o_wdom_rd_ptr_bin(o_wdom_rd_ptr_bin),
    .o_wr_count(o_wr_count),
    .o_wr_full(o_wr_full),
    .o_wr_almost_full(o_wr_almost_full),
    .o_wr_overflow(o_wr_overflow)
  );

  always #5 i_wr_clk = ~i_wr_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] q_addr [$];
  logic [3:0] m_wr, m_s1, m_s2;
  logic       m_full, m_afull, m_ovf;

  function automatic logic [3:0] g2b(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_clear();
    m_wr = '0; m_s1 = '0; m_s2 = '0;
    m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
    q_addr.delete();
  endtask

  // One clock: drive valid, check strobe/address, advance model, check state.
  task automatic tick(input logic v);
    logic       acc;
    logic [3:0] nptr, rdb;
    logic [2:0] a;
    acc = v && !m_full;
    if (acc) q_addr.push_back(m_wr[2:0]);
    i_wr_valid = v;
    #2;
    n_tests++;
    if (o_wr_en !== acc) begin
      n_fail++;
      $display("FAIL wr_en: got %b want %b", o_wr_en, acc);
    end
    if (o_wr_en === 1'b1) begin
      n_tests++;
      if (q_addr.size() == 0) begin
        n_fail++;
        $display("FAIL wr_addr: strobe with empty scoreboard, addr %0d", o_wr_addr);
      end else begin
        a = q_addr.pop_front();
        if (o_wr_addr !== a) begin
          n_fail++;
          $display("FAIL wr_addr: got %0d want %0d", o_wr_addr, a);
        end
      end
    end
    rdb  = g2b(m_s2);
    nptr = m_wr + {3'b0, acc};
    @(posedge i_wr_clk);
`ifdef FIFO_WR_OVERFLOW_DETECT_EN
    if (v && m_full) m_ovf = 1'b1;
`endif
    m_full  = (nptr[3] != rdb[3]) && (nptr[2:0] == rdb[2:0]);
    m_afull = (4'(nptr - rdb) >= 4'd7);
    m_s2 = m_s1;
    m_s1 = i_rdom_rd_ptr_gray;
    m_wr = nptr;
    #1;
    i_wr_valid = 1'b0;
    n_tests++;
    if (o_wr_ptr_bin !== m_wr || o_wr_ptr_gray !== b2g(m_wr) ||
        o_wr_full !== m_full || o_wr_almost_full !== m_afull ||
        o_wr_ready !== !m_full || o_wdom_rd_ptr_bin !== g2b(m_s2) ||
        o_wr_count !== 4'(m_wr - g2b(m_s2)) || o_wr_overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL state: bin=%h gray=%h full=%b af=%b rdy=%b rd=%h cnt=%0d ovf=%b want bin=%h full=%b af=%b rd=%h ovf=%b",
               o_wr_ptr_bin, o_wr_ptr_gray, o_wr_full, o_wr_almost_full,
               o_wr_ready, o_wdom_rd_ptr_bin, o_wr_count, o_wr_overflow,
               m_wr, m_full, m_afull, g2b(m_s2), m_ovf);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    n_tests++;
    if (o_wr_ready !== 1'b1 || o_wr_full !== 1'b0 || o_wr_almost_full !== 1'b0 ||
        o_wr_count !== 4'd0 || o_wr_ptr_bin !== 4'd0 || o_wr_ptr_gray !== 4'd0 ||
        o_wdom_rd_ptr_bin !== 4'd0 || o_wr_overflow !== 1'b0 || o_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: rdy=%b full=%b af=%b cnt=%0d bin=%h gray=%h rd=%h ovf=%b en=%b want reset values",
               tag, o_wr_ready, o_wr_full, o_wr_almost_full, o_wr_count,
               o_wr_ptr_bin, o_wr_ptr_gray, o_wdom_rd_ptr_bin, o_wr_overflow, o_wr_en);
    end
  endtask

  task automatic do_reset();
    i_wr_valid = 1'b0;
    i_rdom_rd_ptr_gray = '0;
    i_wr_rst_n = 1'b0;
    #2;
    @(posedge i_wr_clk);
    #1;
    model_clear();
    i_wr_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    check_reset_vals("reset");
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 7; i++) tick(1'b1);
    n_tests++;
    if (o_wr_almost_full !== 1'b1 || o_wr_count !== 4'd7 || o_wr_full !== 1'b0) begin
      n_fail++;
      $display("FAIL fill7: af=%b cnt=%0d full=%b want 1 7 0",
               o_wr_almost_full, o_wr_count, o_wr_full);
    end
    tick(1'b1);
    n_tests++;
    if (o_wr_full !== 1'b1 || o_wr_ready !== 1'b0 ||
        o_wr_ptr_bin !== 4'b1000 || o_wr_ptr_gray !== 4'b1100) begin
      n_fail++;
      $display("FAIL fill8: full=%b rdy=%b bin=%b gray=%b want 1 0 1000 1100",
               o_wr_full, o_wr_ready, o_wr_ptr_bin, o_wr_ptr_gray);
    end
    tick(1'b1);
    n_tests++;
    if (o_wr_ptr_bin !== 4'b1000) begin
      n_fail++;
      $display("FAIL fill9: bin=%b want 1000", o_wr_ptr_bin);
    end
  endtask

  task automatic test_drain();
    i_rdom_rd_ptr_gray = 4'b0110;
    tick(1'b0);
    tick(1'b0);
    n_tests++;
    if (o_wdom_rd_ptr_bin !== 4'd4 || o_wr_full !== 1'b1) begin
      n_fail++;
      $display("FAIL drain2: rd=%0d full=%b want 4 1", o_wdom_rd_ptr_bin, o_wr_full);
    end
    tick(1'b0);
    n_tests++;
    if (o_wr_full !== 1'b0 || o_wr_count !== 4'd4 || o_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain3: full=%b cnt=%0d rdy=%b want 0 4 1",
               o_wr_full, o_wr_count, o_wr_ready);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] pb, pg;
    logic       saw_wrap;
    int         k;
    do_reset();
    saw_wrap = 1'b0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      i_rdom_rd_ptr_gray = b2g((k >= 2) ? 4'(k - 2) : 4'd0);
      pb = o_wr_ptr_bin;
      pg = o_wr_ptr_gray;
      tick(1'b1);
      k++;
      n_tests++;
      if (o_wr_full !== 1'b0 || $countones(pg ^ o_wr_ptr_gray) != 1) begin
        n_fail++;
        $display("FAIL wrap_step%0d: full=%b gray %b->%b want full 0, one bit change",
                 c, o_wr_full, pg, o_wr_ptr_gray);
      end
      if (pb == 4'b1111 && o_wr_ptr_bin == 4'b0000) begin
        saw_wrap = 1'b1;
        n_tests++;
        if (pg !== 4'b1000 || o_wr_ptr_gray !== 4'b0000) begin
          n_fail++;
          $display("FAIL wrap_gray: %b->%b want 1000->0000", pg, o_wr_ptr_gray);
        end
      end
    end
    n_tests++;
    if (!saw_wrap) begin
      n_fail++;
      $display("FAIL wrap_seen: got 0 want 1");
    end
  endtask

  task automatic test_overflow();
    logic want;
`ifdef FIFO_WR_OVERFLOW_DETECT_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b1);
    n_tests++;
    if (o_wr_overflow !== 1'b0 || o_wr_full !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pre: ovf=%b full=%b want 0 1", o_wr_overflow, o_wr_full);
    end
    tick(1'b1);
    n_tests++;
    if (o_wr_overflow !== want) begin
      n_fail++;
      $display("FAIL ovf_set: got %b want %b", o_wr_overflow, want);
    end
    i_rdom_rd_ptr_gray = 4'b0110;
    for (int i = 0; i < 4; i++) tick(1'b0);
    n_tests++;
    if (o_wr_overflow !== want) begin
      n_fail++;
      $display("FAIL ovf_hold: got %b want %b", o_wr_overflow, want);
    end
    i_wr_rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_wr_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: got %b want 0", o_wr_overflow);
    end
    do_reset();
  endtask

  task automatic test_reset_midway();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1);
    n_tests++;
    if (o_wr_count !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_count: got %0d want 5", o_wr_count);
    end
    i_wr_valid = 1'b1;
    i_wr_rst_n = 1'b0;
    #2;
    i_wr_valid = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    @(posedge i_wr_clk);
    #1;
    model_clear();
    i_wr_rst_n = 1'b1;
    i_wr_valid = 1'b1;
    #1;
    n_tests++;
    if (o_wr_addr !== 3'd0 || o_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL first_addr: addr=%0d en=%b want 0 1", o_wr_addr, o_wr_en);
    end
    tick(1'b1);
    tick(1'b1);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_overflow();
    test_reset_midway();
    n_tests++;
    if (q_addr.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d writes never strobed, want 0", q_addr.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/fifo_wr_ptr_ctrl.md
FIFO_WR_PTR_CTRL -- requirements
Module: fifo_wr_ptr_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 3: address width AW; the pointers are AW+1 bits wide, with the MSB used as the wrap bit.
REQ-002 Parameter DEPTH, default 8: entry count; it SHALL equal 2**ADDR_WIDTH.
REQ-003 Parameter ALMOST_WR_MARGIN, default 1: almost-full threshold is DEPTH-ALMOST_WR_MARGIN.
REQ-004 Parameter N_FLOP_CROSS, default 2, minimum 2: number of synchronizer stages for the incoming read pointer.
REQ-005 i_wr_clk  input  1  the single write-domain clock, rising edge.
REQ-006 i_wr_rst_n  input  1  reset; asynchronous, active-low (fixed).
REQ-007 i_wr_valid  input  1  the producer requests a write.
REQ-008 o_wr_ready  output  1  the block can accept a write.
REQ-009 i_rdom_rd_ptr_gray  input  AW+1  Gray-coded read pointer from the read domain; asynchronous to i_wr_clk.
REQ-010 o_wr_en  output  1  memory write strobe.
REQ-011 o_wr_addr  output  AW  memory write address.
REQ-012 o_wr_ptr_bin  output  AW+1  registered binary write pointer.
REQ-013 o_wr_ptr_gray  output  AW+1  registered Gray write pointer, sent to the read domain.
REQ-014 o_wdom_rd_ptr_bin  output  AW+1  synchronized read pointer, converted to binary.
REQ-015 o_wr_count  output  AW+1  fill level as seen from the write domain.
REQ-016 o_wr_full  output  1  FIFO full.
REQ-017 o_wr_almost_full  output  1  fill level is at or above the almost-full threshold.
REQ-018 o_wr_overflow  output  1  sticky overflow error flag (see Configuration).

Function
REQ-019 A write SHALL be accepted when i_wr_valid && o_wr_ready, and o_wr_ready SHALL equal !o_wr_full.
REQ-020 o_wr_en SHALL equal the accept term combinationally, and o_wr_addr SHALL equal o_wr_ptr_bin[AW-1:0].
REQ-021 On each accepted write, o_wr_ptr_bin SHALL increment by 1 at the next edge, modulo 2**(AW+1), with no saturation.
REQ-022 o_wr_ptr_gray SHALL be registered as bin^(bin>>1) of the next binary pointer, so that it updates on the same edge as o_wr_ptr_bin.
REQ-023 i_rdom_rd_ptr_gray SHALL pass through N_FLOP_CROSS flops, and only the last stage SHALL be used.
REQ-024 o_wdom_rd_ptr_bin SHALL be the combinational Gray-to-binary conversion of the last synchronizer stage; its latency from an input change is N_FLOP_CROSS edges.
REQ-025 o_wr_count SHALL equal o_wr_ptr_bin - o_wdom_rd_ptr_bin computed in AW+1 bits, and its range is 0..DEPTH.
REQ-026 o_wr_full SHALL be registered, and its next value SHALL be computed from the next write pointer and the current o_wdom_rd_ptr_bin: full when the MSBs differ and the low AW bits are equal.
REQ-027 As a consequence of REQ-026, full SHALL assert on the same edge at which the pointer reaches DEPTH entries, and SHALL deassert one edge after o_wdom_rd_ptr_bin advances.
REQ-028 o_wr_almost_full SHALL be registered, with next value (next_ptr - o_wdom_rd_ptr_bin) >= DEPTH-ALMOST_WR_MARGIN.
REQ-029 A valid request while full SHALL be ignored: no pointer change and no o_wr_en.
REQ-030 When a write and a read-pointer advance occur in the same cycle, both SHALL be applied, and the flags SHALL reflect the net count.
REQ-031 The pointer wrap from 2**(AW+1)-1 to 0 SHALL cause no flag glitch, and the Gray output SHALL change exactly one bit per increment.

Reset
REQ-032 When i_wr_rst_n is asserted, all of the following SHALL clear immediately, regardless of the clock, and hold until deassertion:
- pointers, synchronizer stages, o_wr_full, o_wr_almost_full and o_wr_overflow to 0;
- o_wr_ready to 1 and o_wr_count to 0.
REQ-033 Reset during operation SHALL discard the fill state.
REQ-034 The first accept after reset deassertion SHALL write address 0.

Configuration
REQ-035 Macro FIFO_WR_OVERFLOW_DETECT_EN: when defined, o_wr_overflow SHALL set at the edge following any cycle with i_wr_valid && o_wr_full, and SHALL stay set until reset.
REQ-036 When the macro is undefined, o_wr_overflow SHALL be tied to 0 and no overflow logic SHALL be built; all other behaviour SHALL be identical.

Verification
(All scenarios use AW=3, DEPTH=8, margin 1, N_FLOP_CROSS=2.)
REQ-037 Reset, read pointer held at 0 -> required: ready=1, full=0, almost_full=0, count=0, ptr_bin=0, ptr_gray=0.
REQ-038 Eight consecutive writes with the read pointer at 0:
- after the 7th write, almost_full=1 and count=7;
- after the 8th write, full=1, ready=0, ptr_bin=4'b1000 and ptr_gray=4'b1100;
- a 9th valid request produces no o_wr_en and no pointer change.
REQ-039 From full, drive i_rdom_rd_ptr_gray=4'b0110 (binary 4) -> required: o_wdom_rd_ptr_bin=4 two edges later, full=0 and count=4 one edge after that.
REQ-040 Continuous writes with the read pointer trailing by 2 for 20 cycles -> required: ptr_bin wraps 4'b1111->4'b0000, ptr_gray goes 4'b1000->4'b0000, and full never asserts.
REQ-041 Macro defined, valid asserted while full -> required: o_wr_overflow=1 at the next edge and held until reset. Macro undefined, same stimulus -> required: o_wr_overflow stays 0.
REQ-042 Assert reset with count=5 -> required: all outputs return to reset values without a clock edge; after release, the first write uses o_wr_addr=0.
